multdiv_seq: RTL
================

# multdiv_seq

Sequential signed multiply/divide unit in the execute stage, beside the ALU. It receives the same two 32-bit operands the ALU receives and delivers a 32-bit result to the execute/memory latch. Start is a one-cycle pulse from decode. The processor stalls until `data_resultRDY` is asserted. Multiply is radix-2 Booth and divide is restoring, one iteration per cycle, with shifts built from the team's 1-bit shift cell.

## Interface
- No parameters; fixed 32-bit datapath.
- `clock`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state immediately.
- `data_operandA`  in  32  — multiplicand / dividend, two's complement; sampled only on a start edge.
- `data_operandB`  in  32  — multiplier / divisor, two's complement; sampled only on a start edge.
- `ctrl_MULT`  in  1  — start-multiply pulse.
- `ctrl_DIV`  in  1  — start-divide pulse.
- `data_result`  out  32  — result; valid when `data_resultRDY`=1, then held until the next start.
- `data_exception`  out  1  — overflow or divide-by-zero; qualified and held the same way as `data_result`.
- `data_resultRDY`  out  1  — one-cycle completion strobe.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Start edge: a rising edge with `ctrl_MULT` or `ctrl_DIV` high while in IDLE or DONE.
  - If both are high, multiply wins.
  - The start edge latches the operands, clears the 6-bit iteration counter, drives `data_exception` to 0, and enters MUL or DIV.
- Start pulses are ignored in MUL and DIV. Decode never issues them while stalled.
- MUL datapath:
  - 65-bit register {A[31:0], Q[31:0], q₋₁}, initialised to {0, operandB, 0}.
  - Each iteration examines {Q[0], q₋₁}:
    - 01: A += M.
    - 10: A −= M.
    - 00 or 11: no add.
  - The register then shifts right arithmetically by 1.
  - After 32 iterations, {A,Q} is the 64-bit signed product.
  - `data_result` = Q.
  - `data_exception` = 1 iff A ≠ {32{Q[31]}}, i.e. the product does not fit in 32 signed bits.
- DIV datapath:
  - Operands are converted to magnitudes on the start edge (|−2³¹| = 0x80000000 unsigned).
  - Registers: 33-bit remainder R = 0 and 32-bit quotient Qd = |A|.
  - Each iteration:
    - Shift {R,Qd} left by 1.
    - T = R − |B|.
    - If T ≥ 0: R = T and Qd[0] = 1.
    - Else: Qd[0] = 0.
  - After 32 iterations, the quotient magnitude is negated when the operand signs differ. This truncates toward zero. The remainder is discarded.
- DIV special cases:
  - Divisor = 0: `data_result` = 0, `data_exception` = 1.
  - 0x80000000 / 0xFFFFFFFF: `data_result` = 0x80000000, `data_exception` = 1.
  - All other divides: `data_exception` = 0.
- DONE lasts exactly one cycle. It returns to IDLE, or enters MUL/DIV if a start edge occurs in DONE.
- Reset, including mid-operation:
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, state = IDLE, counter = 0.
  - No strobe is produced for the aborted operation.

## Timing
- Start edge = edge E0. Iterations occur on edges E1–E32.
- The edge E33 registers the final result/exception, enters DONE, and raises `data_resultRDY`.
- `data_resultRDY` is high for the single cycle between E33 and E34, then low.
- Latency is fixed at 33 cycles for multiply, divide and all special cases, including divide-by-zero.
- Back-to-back operation: a start sampled at E34 (the DONE cycle) begins the next operation. The new result strobes after E67.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- `data_result` and `data_exception` are stable from E33 until the next start edge.
- Operand inputs may change freely after E0.

## Test plan
- MULT, A=7, B=0xFFFFFFFD (−3) → after E33, result 0xFFFFFFEB (−21), exception 0; `data_resultRDY` high for exactly one cycle.
- MULT, A=0x00010000, B=0x00010000 → result 0x00000000, exception 1.
- MULT, A=0x80000000, B=0xFFFFFFFF → result 0x80000000, exception 1.
- DIV, A=0xFFFFFFF9 (−7), B=2 → result 0xFFFFFFFD (−3), exception 0.
- DIV, A=100, B=7 → result 14.
- DIV, A=5, B=0 → result 0, exception 1 at E33.
- Overlapping control: both `ctrl_MULT` and `ctrl_DIV` high with A=6, B=3 → result 18 (multiply).
- Start pulse at E10 of a running operation → ignored.
- Reset asserted asynchronously mid-multiply at cycle 10 → all outputs 0 immediately, no strobe; a new DIV 9/3 then yields 3 after 33 cycles.
- DIV 20/4, then MULT 3×4 started in the DONE cycle → strobe after E33 with 5, then strobe after E67 with 12.

Source files
------------

// File: rtl/multdiv_seq.sv
// Sequential signed multiply/divide unit. Multiply is radix-2 Booth and divide is restoring.
// Both do one iteration per cycle, with a fixed 33-cycle latency to a one-cycle result strobe.

module multdiv_shift1 #(
   parameter int W = 8
) (
   input  logic         left,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // left: logical shift left with zero fill; otherwise arithmetic shift right
   assign q = left ? {d[W-2:0], 1'b0} : {d[W-1], d[W-1:1]};
endmodule

module multdiv_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state;
   logic [5:0]  count;
   // acc/lo/opb are shared: Booth A/Q/M in MUL, remainder/quotient/|B| in DIV.
   // acc carries a guard bit so A-M cannot wrap when M = -2^31.
   logic [32:0] acc;
   logic [31:0] lo;
   logic [31:0] opb;
   logic        qm1;
   logic        div_neg;
   logic        div_zero;
   logic        div_ovf;

   logic        start;
   logic [32:0] booth_sum;
   logic [65:0] mul_sh;
   logic [64:0] div_sh;
   logic [33:0] div_trial;

   assign start = ctrl_MULT | ctrl_DIV;

   always_comb begin
      // NOTE: default first so every path assigns booth_sum and no latch is inferred.
      booth_sum = acc;
      case ({lo[0], qm1})
         2'b01:   booth_sum = acc + {opb[31], opb};
         2'b10:   booth_sum = acc - {opb[31], opb};
         default: booth_sum = acc;
      endcase
   end

   multdiv_shift1 #(.W(66)) u_mul_shift (
      .left (1'b0),
      .d    ({booth_sum, lo, qm1}),
      .q    (mul_sh)
   );

   multdiv_shift1 #(.W(65)) u_div_shift (
      .left (1'b1),
      .d    ({acc, lo}),
      .q    (div_sh)
   );

   assign div_trial = {1'b0, div_sh[64:32]} - {2'b00, opb};

   // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         count          <= '0;
         acc            <= '0;
         lo             <= '0;
         opb            <= '0;
         qm1            <= 1'b0;
         div_neg        <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (start) begin
                  count          <= '0;
                  acc            <= '0;
                  qm1            <= 1'b0;
                  data_exception <= 1'b0;
                  if (ctrl_MULT) begin
                     lo    <= data_operandB;
                     opb   <= data_operandA;
                     state <= MUL;
                  end else begin
                     lo       <= data_operandA[31] ? -data_operandA : data_operandA;
                     opb      <= data_operandB[31] ? -data_operandB : data_operandB;
                     div_neg  <= data_operandA[31] ^ data_operandB[31];
                     div_zero <= (data_operandB == 32'h0000_0000);
                     div_ovf  <= (data_operandA == 32'h8000_0000) &&
                                 (data_operandB == 32'hFFFF_FFFF);
                     state    <= DIV;
                  end
               end
            end

            MUL: begin
               if (count == 6'd32) begin
                  data_result    <= lo;
                  data_exception <= (acc != {33{lo[31]}});
                  data_resultRDY <= 1'b1;
                  state          <= DONE;
               end else begin
                  acc   <= mul_sh[65:33];
                  lo    <= mul_sh[32:1];
                  qm1   <= mul_sh[0];
                  count <= count + 6'd1;
               end
            end

            DIV: begin
               if (count == 6'd32) begin
                  if (div_zero) begin
                     data_result    <= '0;
                     data_exception <= 1'b1;
                  end else begin
                     data_result    <= div_neg ? -lo : lo;
                     data_exception <= div_ovf;
                  end
                  data_resultRDY <= 1'b1;
                  state          <= DONE;
               end else begin
                  count <= count + 6'd1;
                  if (!div_trial[33]) begin
                     acc <= div_trial[32:0];
                     lo  <= {div_sh[31:1], 1'b1};
                  end else begin
                     acc <= div_sh[64:32];
                     lo  <= div_sh[31:0];
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
